// File: rtl/modrm_field_sequencer.sv
// Walks an x86 32-bit ModR/M group (ModR/M, optional SIB, optional disp8/disp32)
// one byte at a time and presents the parsed fields as a single handshake group.
module modrm_field_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_modrm,
  output logic [7:0]  out_sib,
  output logic        out_sib_present,
  output logic [31:0] out_disp,
  output logic        out_disp_present,
  output logic        out_disp8,
  output logic [2:0]  out_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIB  = 2'd1,
    DISP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  disp_cnt;
  logic        accept;
  logic        sib_needed;
  logic [2:0]  modrm_disp_len;
  logic [2:0]  sib_disp_len;
  logic        last_disp;
  logic        group_taken;

  // Displacement length from mod, rm and (when a SIB follows) the SIB base field.
  function automatic logic [2:0] disp_len_f(input logic [1:0] mod,
                                            input logic [2:0] rm,
                                            input logic [2:0] base);
    logic [2:0] len;
    len = 3'd0;
    case (mod)
      2'b01: len = 3'd1;
      2'b10: len = 3'd4;
      2'b00: begin
        if (rm == 3'b101)
          len = 3'd4;
        else if (rm == 3'b100 && base == 3'b101)
          len = 3'd4;
      end
      default: len = 3'd0;
    endcase
    return len;
  endfunction

  assign in_ready       = (state != DONE) && !abort;
  assign accept         = in_valid && in_ready;
  assign out_valid      = (state == DONE);
  assign group_taken    = (state == DONE) && out_ready;
  assign sib_needed     = (in_byte[7:6] != 2'b11) && (in_byte[2:0] == 3'b100);
  assign modrm_disp_len = disp_len_f(in_byte[7:6], in_byte[2:0], 3'b000);
  assign sib_disp_len   = disp_len_f(out_modrm[7:6], out_modrm[2:0], in_byte[2:0]);
  // out_disp8 is set on entry to DISP, so it doubles as the 1-vs-4 byte length.
  assign last_disp      = out_disp8 || (disp_cnt == 2'd3);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sib_needed)
              state_next = SIB;
            else if (modrm_disp_len != 3'd0)
              state_next = DISP;
            else
              state_next = DONE;
          end
        end
        SIB: begin
          if (accept)
            state_next = (sib_disp_len != 3'd0) ? DISP : DONE;
        end
        DISP: begin
          if (accept && last_disp)
            state_next = DONE;
        end
        DONE: begin
          if (out_ready)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture registers double as the output fields; cleared on abort or hand-off.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      disp_cnt         <= 2'd0;
      out_modrm        <= 8'h00;
      out_sib          <= 8'h00;
      out_sib_present  <= 1'b0;
      out_disp         <= 32'h0;
      out_disp_present <= 1'b0;
      out_disp8        <= 1'b0;
      out_len          <= 3'd0;
    end else if (abort || group_taken) begin
      disp_cnt         <= 2'd0;
      out_modrm        <= 8'h00;
      out_sib          <= 8'h00;
      out_sib_present  <= 1'b0;
      out_disp         <= 32'h0;
      out_disp_present <= 1'b0;
      out_disp8        <= 1'b0;
      out_len          <= 3'd0;
    end else if (accept) begin
      out_len <= out_len + 3'd1;
      case (state)
        IDLE: begin
          out_modrm <= in_byte;
          if (!sib_needed && modrm_disp_len == 3'd1)
            out_disp8 <= 1'b1;
        end
        SIB: begin
          out_sib         <= in_byte;
          out_sib_present <= 1'b1;
          if (sib_disp_len == 3'd1)
            out_disp8 <= 1'b1;
        end
        DISP: begin
          out_disp_present <= 1'b1;
          disp_cnt         <= disp_cnt + 2'd1;
          if (out_disp8)
            out_disp <= {{24{in_byte[7]}}, in_byte};
          else
            out_disp[{disp_cnt, 3'b000} +: 8] <= in_byte;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modrm_field_sequencer.sv
// Directed-vector bench for modrm_field_sequencer with hand-computed expectations.
module tb_modrm_field_sequencer;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_modrm;
  logic [7:0]  out_sib;
  logic        out_sib_present;
  logic [31:0] out_disp;
  logic        out_disp_present;
  logic        out_disp8;
  logic [2:0]  out_len;

  int checks_total;
  int checks_passed;

  modrm_field_sequencer dut (
    .clk              (clk),
    .clr              (clr),
    .in_valid         (in_valid),
    .in_byte          (in_byte),
    .in_ready         (in_ready),
    .abort            (abort),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_modrm        (out_modrm),
    .out_sib          (out_sib),
    .out_sib_present  (out_sib_present),
    .out_disp         (out_disp),
    .out_disp_present (out_disp_present),
    .out_disp8        (out_disp8),
    .out_len          (out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    else
      checks_passed++;
  endtask

  // One byte offered for exactly one clock edge; a bubble follows.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic take_group();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    abort     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_len", 32'(out_len), 32'd0);
    checkOutput("rst_modrm", 32'(out_modrm), 32'd0);
    checkOutput("rst_disp", out_disp, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // mod 11: single-byte group
    applyStimulus(8'hC0);
    checkOutput("c0_valid", 32'(out_valid), 32'd1);
    checkOutput("c0_len", 32'(out_len), 32'd1);
    checkOutput("c0_sibp", 32'(out_sib_present), 32'd0);
    checkOutput("c0_dispp", 32'(out_disp_present), 32'd0);
    checkOutput("c0_modrm", 32'(out_modrm), 32'hC0);
    take_group();
    checkOutput("c0_taken_valid", 32'(out_valid), 32'd0);
    checkOutput("c0_taken_modrm", 32'(out_modrm), 32'd0);

    // SIB plus sign-extended disp8
    applyStimulus(8'h44);
    applyStimulus(8'h24);
    checkOutput("44_mid_valid", 32'(out_valid), 32'd0);
    applyStimulus(8'hF0);
    checkOutput("44_valid", 32'(out_valid), 32'd1);
    checkOutput("44_sib", 32'(out_sib), 32'h24);
    checkOutput("44_sibp", 32'(out_sib_present), 32'd1);
    checkOutput("44_disp", out_disp, 32'hFFFFFFF0);
    checkOutput("44_disp8", 32'(out_disp8), 32'd1);
    checkOutput("44_dispp", 32'(out_disp_present), 32'd1);
    checkOutput("44_len", 32'(out_len), 32'd3);
    take_group();

    // disp32 without SIB
    applyStimulus(8'h05);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    applyStimulus(8'h34);
    checkOutput("05_mid_valid", 32'(out_valid), 32'd0);
    applyStimulus(8'h12);
    checkOutput("05_valid", 32'(out_valid), 32'd1);
    checkOutput("05_disp", out_disp, 32'h12345678);
    checkOutput("05_disp8", 32'(out_disp8), 32'd0);
    checkOutput("05_sibp", 32'(out_sib_present), 32'd0);
    checkOutput("05_len", 32'(out_len), 32'd5);
    take_group();

    // SIB base 101 with mod 00 forces disp32
    applyStimulus(8'h04);
    applyStimulus(8'h25);
    applyStimulus(8'h04);
    applyStimulus(8'h03);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    checkOutput("0425_valid", 32'(out_valid), 32'd1);
    checkOutput("0425_disp", out_disp, 32'h01020304);
    checkOutput("0425_len", 32'(out_len), 32'd6);
    take_group();

    applyStimulus(8'h04);
    applyStimulus(8'h24);
    checkOutput("0424_valid", 32'(out_valid), 32'd1);
    checkOutput("0424_len", 32'(out_len), 32'd2);
    checkOutput("0424_dispp", 32'(out_disp_present), 32'd0);
    checkOutput("0424_disp", out_disp, 32'd0);
    take_group();

    // Back-pressure: group held, input blocked
    applyStimulus(8'hC1);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_modrm", 32'(out_modrm), 32'hC1);
      checkOutput("hold_len", 32'(out_len), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("take_no_accept_len", 32'(out_len), 32'd0);
    checkOutput("take_no_accept_modrm", 32'(out_modrm), 32'd0);

    // Abort mid-group
    applyStimulus(8'h84);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h33;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_len", 32'(out_len), 32'd0);
    checkOutput("abort_modrm", 32'(out_modrm), 32'd0);
    applyStimulus(8'hC3);
    checkOutput("c3_valid", 32'(out_valid), 32'd1);
    checkOutput("c3_len", 32'(out_len), 32'd1);
    checkOutput("c3_modrm", 32'(out_modrm), 32'hC3);

    // Abort drops a pending group
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_done_valid", 32'(out_valid), 32'd0);

    // Async reset mid-group
    applyStimulus(8'h05);
    applyStimulus(8'h01);
    #2;
    clr = 1'b0;
    #1;
    checkOutput("rst_mid_len", 32'(out_len), 32'd0);
    checkOutput("rst_mid_modrm", 32'(out_modrm), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    applyStimulus(8'hC0);
    checkOutput("post_rst_len", 32'(out_len), 32'd1);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    take_group();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
